// File: rtl/sat_accum_stage.sv
// sat_accum_stage: accumulates a framed stream of signed samples with per-step
// saturation, then holds the frame result until the downstream side accepts it.
module sat_accum_stage #(
  parameter int BITWIDTH = 32,
  parameter int COUNT_W  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BITWIDTH-1:0] in_data,
  input  logic                in_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [BITWIDTH-1:0] out_data,
  output logic [COUNT_W-1:0]  out_count,
  output logic                out_sat
);
  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;
  state_t              r_state;
  logic [BITWIDTH-1:0] r_acc;
  logic [COUNT_W-1:0]  r_cnt;
  logic                r_sat;
  logic [BITWIDTH:0]   w_sum;
  logic                w_ovf;
  logic [BITWIDTH-1:0] w_add;
  logic                w_in_xfer;
  // One guard bit: overflow exactly when guard and result sign disagree.
  assign w_sum     = {r_acc[BITWIDTH-1], r_acc} + {in_data[BITWIDTH-1], in_data};
  assign w_ovf     = w_sum[BITWIDTH] ^ w_sum[BITWIDTH-1];
  assign w_add     = !w_ovf ? w_sum[BITWIDTH-1:0]
                   : w_sum[BITWIDTH] ? {1'b1, {(BITWIDTH-1){1'b0}}}
                   : {1'b0, {(BITWIDTH-1){1'b1}}};
  assign in_ready  = r_state != HOLD;
  assign w_in_xfer = in_valid && in_ready;
  assign out_valid = r_state == HOLD;
  assign out_data  = r_acc;
  assign out_count = r_cnt;
  assign out_sat   = r_sat;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_sat   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_in_xfer) begin
          r_acc   <= in_data;
          r_cnt   <= COUNT_W'(1);
          r_sat   <= 1'b0;
          r_state <= in_last ? HOLD : ACCUM;
        end
        ACCUM: if (w_in_xfer) begin
          r_acc   <= w_add;
          r_cnt   <= &r_cnt ? r_cnt : r_cnt + 1'b1;
          r_sat   <= r_sat | w_ovf;
          r_state <= in_last ? HOLD : ACCUM;
        end
        HOLD: if (out_ready) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/sat_accum_stage.md
SAT_ACCUM_STAGE -- requirements
Module: sat_accum_stage

Interface
REQ-001 SHALL have parameter BITWIDTH, default 32, giving the signed two's-complement sample and accumulator width.
REQ-002 SHALL have parameter COUNT_W, default 8, giving the beat-counter width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port in_valid  input  1  upstream sample valid.
REQ-006 SHALL have port in_ready  output  1  stage can accept a sample.
REQ-007 SHALL have port in_data  input  BITWIDTH  signed sample.
REQ-008 SHALL have port in_last  input  1  final sample of a frame; qualified by in_valid.
REQ-009 SHALL have port out_valid  output  1  frame result available.
REQ-010 SHALL have port out_ready  input  1  downstream accepts result.
REQ-011 SHALL have port out_data  output  BITWIDTH  saturated frame sum.
REQ-012 SHALL have port out_count  output  COUNT_W  beats in frame, saturating.
REQ-013 SHALL have port out_sat  output  1  sticky flag: at least one clamp occurred in the frame.

Function
REQ-014 SHALL define an input transfer as in_valid=1 and in_ready=1 on a rising clk edge, and an output transfer as out_valid=1 and out_ready=1.
REQ-015 SHALL implement a three-state FSM: IDLE, ACCUM, HOLD.
REQ-016 SHALL drive in_ready=1 in IDLE and ACCUM and 0 in HOLD; in_data and in_last are ignored without a transfer.
REQ-017 SHALL, on a transfer in IDLE, load acc=in_data, cnt=1 and sat=0, then go to HOLD if in_last=1, else to ACCUM.
REQ-018 SHALL, on a transfer in ACCUM, update acc=satadd(acc,in_data), cnt=min(cnt+1, 2^COUNT_W-1) and sat=sat OR ovf, then go to HOLD if in_last=1, else stay in ACCUM.
REQ-019 SHALL compute satadd with BITWIDTH+1-bit sign-extended addition.
 - ovf = operands share a sign and the truncated sum sign differs.
 - positive ovf -> 2^(BITWIDTH-1)-1; negative ovf -> -2^(BITWIDTH-1); otherwise the truncated sum.
REQ-020 SHALL clamp per step; later in-range additions proceed from the clamped value.
REQ-021 SHALL assert out_valid=1 only in HOLD, with out_data=acc, out_count=cnt and out_sat=sat, held stable until the output transfer.
REQ-022 SHALL move from HOLD to IDLE on the output transfer; the first input transfer of the next frame occurs no earlier than the following cycle.
REQ-023 SHALL assert out_valid in the cycle after the in_last transfer (latency 1); minimum frame period is N+1 cycles for N beats.
REQ-024 SHALL keep out_valid=0 while in IDLE or ACCUM; out_data, out_count and out_sat are don't-care but registered (no combinational path from in_* to out_*).
REQ-025 SHALL have no combinational path from out_ready to in_ready other than through the registered state.

Reset
REQ-026 SHALL, while rst_n=0 and regardless of clk: state=IDLE, acc=0, cnt=0, sat=0, out_valid=0, out_data=0, out_count=0, out_sat=0; in_ready=1 after reset release.
REQ-027 SHALL discard any partial or held frame on reset mid-operation, with no result emitted for it.

Verification (BITWIDTH=8, COUNT_W=4)
REQ-028 SHALL cover a normal frame: beats 10, 20, -5 (last) with out_ready=1 -> out_valid one cycle after the last beat; out_data=25, out_count=3, out_sat=0.
REQ-029 SHALL cover saturation:
 - positive: 100, 50 (last) -> out_data=127, out_sat=1.
 - negative: -100, -100, 100 (last) -> out_data=-28, out_sat=1.
REQ-030 SHALL cover backpressure: out_ready=0 for 3 cycles in HOLD with in_valid=1 -> in_ready=0, no beat accepted, out_* stable; out_ready=1 -> IDLE next cycle, pending beat then accepted as first of new frame.
REQ-031 SHALL cover a single-beat frame: -128 (last) -> out_data=-128, out_count=1, out_sat=0.
REQ-032 SHALL cover count saturation: 20 beats of 1, last on 20th -> out_data=20, out_count=15, out_sat=0.
REQ-033 SHALL cover reset mid-frame: assert rst_n=0 after 2 beats of 50 -> out_valid=0 immediately; after release, frame 3 (last) -> out_data=3, out_count=1.
